// File: rtl/clk_ratio_pkg.sv
// ============================================================================
// Module   : clk_ratio_pkg
// Desc     : Shared FSM state type and constants for clk_ratio_meter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } clk_ratio_state_t;

    // Largest |high - low| still reported as balanced; 1 lets odd divisors pass.
    localparam int CLK_RATIO_BAL_TOL = 1;

endpackage

`default_nettype wire

// File: rtl/clk_ratio_meter_edge_sync.sv
// ============================================================================
// Module   : edge_sync
// Desc     : Conditions mon_clk (optional synchronizer) and detects its edges.
// Macro    : CLK_RATIO_SYNC_EN - insert a SYNC_STAGES-deep synchronizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic mon_clk,
    output logic s,
    output logic rise,
    output logic fall
);

    logic w_s;
    logic r_s_d;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_depth
            $error("edge_sync: SYNC_STAGES must be at least 2");
        end
    endgenerate

`ifdef CLK_RATIO_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], mon_clk};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
`else
    assign w_s = mon_clk;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign s    = w_s;
    assign rise = w_s & ~r_s_d;
    assign fall = ~w_s & r_s_d;

endmodule

`default_nettype wire

// File: rtl/clk_ratio_meter.sv
// ============================================================================
// Module   : clk_ratio_meter
// Desc     : Measures high/low/period of a divided clock sampled in clk_in.
// Macro    : CLK_RATIO_SYNC_EN - synchronize mon_clk before measuring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_ratio_meter
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             mon_clk,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             balanced,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_bal_tol = CNT_W'(CLK_RATIO_BAL_TOL);

    clk_ratio_state_t r_state;
    clk_ratio_state_t w_state_nxt;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_lcnt;
    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] w_diff;
    logic             w_publish;
    logic             w_hcnt_load;
    logic             w_hcnt_inc;
    logic             w_lcnt_load;
    logic             w_lcnt_inc;
    logic             w_cnt_sat;
    logic             w_in_wait;
    logic             w_wait_sat;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .mon_clk (mon_clk),
        .s       (w_s),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (!w_s) w_state_nxt = ARMED;
            ARMED:   if (w_rise) w_state_nxt = HIGH;
            HIGH: begin
                if (w_fall)         w_state_nxt = LOW;
                else if (w_cnt_sat) w_state_nxt = IDLE;
            end
            LOW: begin
                if (w_rise)         w_state_nxt = HIGH;
                else if (w_cnt_sat) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_publish   = 1'b0;
        w_hcnt_load = 1'b0;
        w_hcnt_inc  = 1'b0;
        w_lcnt_load = 1'b0;
        w_lcnt_inc  = 1'b0;
        w_cnt_sat   = 1'b0;
        unique case (r_state)
            ARMED: w_hcnt_load = w_rise;
            HIGH: begin
                if (w_fall)                 w_lcnt_load = 1'b1;
                else if (r_hcnt == c_cnt_max) w_cnt_sat = 1'b1;
                else                          w_hcnt_inc  = 1'b1;
            end
            LOW: begin
                if (w_rise) begin
                    w_publish   = 1'b1;
                    w_hcnt_load = 1'b1;
                end else if (r_lcnt == c_cnt_max) begin
                    w_cnt_sat   = 1'b1;
                end else begin
                    w_lcnt_inc  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_in_wait  = (r_state == IDLE) || (r_state == ARMED);
    assign w_wait_sat = w_in_wait && (r_wait == c_cnt_max);
    assign w_diff     = (r_hcnt >= r_lcnt) ? (r_hcnt - r_lcnt) : (r_lcnt - r_hcnt);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_hcnt     <= '0;
            r_lcnt     <= '0;
            r_wait     <= '0;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            balanced   <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wait <= '0;
            end else if (w_in_wait && !w_wait_sat) begin
                r_wait <= r_wait + 1'b1;
            end

            if (w_hcnt_load)     r_hcnt <= c_cnt_one;
            else if (w_hcnt_inc) r_hcnt <= r_hcnt + 1'b1;

            if (w_lcnt_load)     r_lcnt <= c_cnt_one;
            else if (w_lcnt_inc) r_lcnt <= r_lcnt + 1'b1;

            meas_valid <= w_publish;
            if (w_publish) begin
                high_cnt <= r_hcnt;
                low_cnt  <= r_lcnt;
                period   <= {1'b0, r_hcnt} + {1'b0, r_lcnt};
                balanced <= (w_diff <= c_bal_tol);
            end

            // A good publish is the only thing besides reset that clears stuck.
            if (w_publish) begin
                stuck <= 1'b0;
            end else if (w_cnt_sat || w_wait_sat) begin
                stuck <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
